// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types, funct3 codes and helpers for the load/store
//                unit: FSM state encoding, access-size decode and the
//                misalignment predicate.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } lsu_size_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // The unsigned codes only exist for loads; on a store every code that is
   // not SB/SH behaves as a full word.
   function automatic lsu_size_t access_size(input logic       i_is_load,
                                             input logic [2:0] i_funct3);
      lsu_size_t v;
      if (i_funct3 == F3_B || (i_is_load && i_funct3 == F3_BU))
         v = SZ_B;
      else if (i_funct3 == F3_H || (i_is_load && i_funct3 == F3_HU))
         v = SZ_H;
      else
         v = SZ_W;
      return v;
   endfunction

   function automatic logic is_misaligned(input logic       i_is_load,
                                          input logic [2:0] i_funct3,
                                          input logic [1:0] i_addr_lo);
      logic v;
      case (access_size(i_is_load, i_funct3))
         SZ_B:    v = 1'b0;
         SZ_H:    v = i_addr_lo[0];
         default: v = (i_addr_lo != 2'b00);
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data aligner. Picks the byte / halfword /
//                word out of the bus read data using the low address bits and
//                sign- or zero-extends it to 32 bits.
//  Revision    : 1.0 - initial release
//  Ports       : i_rdata   [31:0] raw bus read data
//                i_addr_lo [1:0]  byte offset inside the word
//                i_funct3  [2:0]  load size/sign code
//                o_data    [31:0] extended load result
// ============================================================================
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // Halfword selection only looks at a[1]; a[0] is either rejected
      // upstream or deliberately ignored.
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_data = {24'h000000, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_data = {16'h0000, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory-stage data-access unit. Converts a pipelined load or
//                store into a req/gnt/rvalid bus transaction, generates byte
//                enables and lane-replicated write data, extends load data and
//                stalls the pipeline until the access retires.
//  Revision    : 1.0 - initial release
//  Config      : LSU_MISALIGN_CHECK_EN - when defined, misaligned half/word
//                accesses are rejected without a bus request and flagged on
//                misaligned_o; when undefined the extra low address bits are
//                ignored and misaligned_o is tied low.
//  Parameters  : TIMEOUT - cycles waited for grant or rvalid before abort
//  Ports       : clk, rst (async, active high)
//                load_m, store_m, funct3_m, alu_out_m, op_b_m  - memory stage
//                stall_o                                       - pipeline hold
//                mem_req_o, mem_we_o, mem_addr_o, mem_be_o,
//                mem_wdata_o, mem_gnt_i, mem_rvalid_i,
//                mem_rdata_i                                   - data bus
//                load_data_w, load_valid_w                     - write-back
//                misaligned_o, bus_err_o                       - error pulses
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_m,
   input  logic        store_m,
   input  logic [2:0]  funct3_m,
   input  logic [31:0] alu_out_m,
   input  logic [31:0] op_b_m,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] load_data_w,
   output logic        load_valid_w,
   output logic        misaligned_o,
   output logic        bus_err_o
);

   localparam int             CNT_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_req;
   logic             r_we;
   logic [31:0]      r_addr;
   logic [3:0]       r_be;
   logic [31:0]      r_wdata;
   logic [2:0]       r_f3;
   logic [1:0]       r_alo;
   logic [31:0]      r_load_data;
   logic             r_load_valid;
   logic             r_bus_err;

   lsu_size_t        w_size;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_aligned;
   logic             w_access;

   assign w_access = load_m | store_m;

   // Byte enables and replicated write data for the incoming access. A load
   // (including load+store together) gets the same enable pattern, which the
   // bus may use or ignore.
   always_comb begin
      w_size  = access_size(load_m, funct3_m);
      w_be    = 4'b1111;
      w_wdata = op_b_m;
      case (w_size)
         SZ_B: begin
            w_be    = 4'b0001 << alu_out_m[1:0];
            w_wdata = {4{op_b_m[7:0]}};
         end
         SZ_H: begin
            w_be    = 4'b0011 << {alu_out_m[1], 1'b0};
            w_wdata = {2{op_b_m[15:0]}};
         end
         default: ;
      endcase
   end

   load_align u_load_align (
      .i_rdata   (mem_rdata_i),
      .i_addr_lo (r_alo),
      .i_funct3  (r_f3),
      .o_data    (w_aligned)
   );

`ifdef LSU_MISALIGN_CHECK_EN
   logic r_misal;
   assign misaligned_o = r_misal;
`else
   assign misaligned_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_be         <= '0;
         r_wdata      <= '0;
         r_f3         <= '0;
         r_alo        <= '0;
         r_load_data  <= '0;
         r_load_valid <= 1'b0;
         r_bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
         r_misal      <= 1'b0;
`endif
      end else begin
         // Pulse outputs are only ever high for the RESP cycle.
         r_load_valid <= 1'b0;
         r_bus_err    <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
         r_misal      <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  r_we    <= ~load_m;
                  r_addr  <= {alu_out_m[31:2], 2'b00};
                  r_be    <= w_be;
                  r_wdata <= w_wdata;
                  r_f3    <= funct3_m;
                  r_alo   <= alu_out_m[1:0];
                  r_cnt   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
                  if (is_misaligned(load_m, funct3_m, alu_out_m[1:0])) begin
                     r_misal     <= 1'b1;
                     r_load_data <= '0;
                     r_state     <= S_RESP;
                  end else
`endif
                  begin
                     r_req   <= 1'b1;
                     r_state <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_gnt_i) begin
                  r_req   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= r_we ? S_RESP : S_WAIT;
               end else if (r_cnt == C_LAST) begin
                  r_req     <= 1'b0;
                  r_bus_err <= 1'b1;
                  if (!r_we)
                     r_load_data <= '0;
                  r_state   <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  r_load_data  <= w_aligned;
                  r_load_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (r_cnt == C_LAST) begin
                  r_load_data <= '0;
                  r_bus_err   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // The IDLE term is combinational so the instruction is held in the very
   // cycle it reaches the memory stage.
   assign stall_o = ((r_state == S_IDLE) && w_access) ||
                    (r_state == S_REQ) || (r_state == S_WAIT);

   assign mem_req_o    = r_req;
   assign mem_we_o     = r_we;
   assign mem_addr_o   = r_addr;
   assign mem_be_o     = r_be;
   assign mem_wdata_o  = r_wdata;
   assign load_data_w  = r_load_data;
   assign load_valid_w = r_load_valid;
   assign bus_err_o    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. Directed cases plus
//                randomized accesses; expected bus handshakes and responses
//                are queued at issue time and checked by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

   localparam int TIMEOUT = 16;
`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit MISAL_EN = 1'b1;
`else
   localparam bit MISAL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        load_m, store_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_out_m, op_b_m;
   logic        stall_o, mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] load_data_w;
   logic        load_valid_w, misaligned_o, bus_err_o;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .load_m(load_m), .store_m(store_m), .funct3_m(funct3_m),
      .alu_out_m(alu_out_m), .op_b_m(op_b_m),
      .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .load_data_w(load_data_w), .load_valid_w(load_valid_w),
      .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic [2:0]  flags;      // {misaligned, bus_err, load_valid}
      logic        chk_data;
      logic [31:0] data;
   } rsp_exp_t;

   bus_exp_t bus_q[$];
   rsp_exp_t rsp_q[$];
   bus_exp_t mon_b;
   rsp_exp_t mon_r;

   logic [31:0] ref_mem [16];
   logic [31:0] bus_mem [16];

   int          gnt_delay = 0;
   int          rv_delay  = 0;
   int          gnt_cnt   = 0;
   bit          rv_pending = 1'b0;
   int          rv_cnt    = 0;
   logic [31:0] rv_data   = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int msize(input logic ld, input logic [2:0] f3);
      if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
      if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
      return 4;
   endfunction

   function automatic int moff(input int n, input logic [31:0] addr);
      if (n == 1) return int'(addr[1:0]);
      if (n == 2) return addr[1] ? 2 : 0;
      return 0;
   endfunction

   function automatic logic [31:0] mload(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] word);
      int n;
      logic [31:0] v;
      n = msize(1'b1, f3);
      v = word >> (8 * moff(n, addr));
      if (n == 1) begin
         v = v & 32'h0000_00FF;
         if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (n == 2) begin
         v = v & 32'h0000_FFFF;
         if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic bit mmisal(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
      int n;
      n = msize(ld, f3);
      return MISAL_EN && ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00));
   endfunction

   // ---------------- bus responder ----------------
   initial begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(posedge clk); #1;
         mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
         if (rv_pending) begin
            if (rv_cnt == 0) begin
               mem_rvalid_i = 1'b1; mem_rdata_i = rv_data; rv_pending = 1'b0;
            end else rv_cnt--;
         end else if (mem_req_o) begin
            if (gnt_cnt >= gnt_delay) begin
               mem_gnt_i = 1'b1; gnt_cnt = 0;
               if (mem_we_o) begin
                  for (int l = 0; l < 4; l++)
                     if (mem_be_o[l]) bus_mem[mem_addr_o[5:2]][8*l +: 8] = mem_wdata_o[8*l +: 8];
               end else begin
                  rv_pending = 1'b1; rv_cnt = rv_delay; rv_data = bus_mem[mem_addr_o[5:2]];
               end
            end else gnt_cnt++;
         end else gnt_cnt = 0;
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_req_o && mem_gnt_i) begin
               if (bus_q.size() == 0) chk("bus_unexpected", 32'(mem_req_o), 32'd0);
               else begin
                  mon_b = bus_q.pop_front();
                  chk("bus_we", 32'(mem_we_o), 32'(mon_b.we));
                  chk("bus_addr", mem_addr_o, mon_b.addr);
                  if (mon_b.we) begin
                     chk("bus_be", 32'(mem_be_o), 32'(mon_b.be));
                     chk("bus_wdata", mem_wdata_o, mon_b.wdata);
                  end
               end
            end
            if (load_valid_w || bus_err_o || misaligned_o) begin
               if (rsp_q.size() == 0)
                  chk("rsp_unexpected", 32'({misaligned_o, bus_err_o, load_valid_w}), 32'd0);
               else begin
                  mon_r = rsp_q.pop_front();
                  chk("rsp_flags", 32'({misaligned_o, bus_err_o, load_valid_w}), 32'(mon_r.flags));
                  if (mon_r.chk_data) chk("load_data", load_data_w, mon_r.data);
                  if (bus_err_o) chk("err_req_low", 32'(mem_req_o), 32'd0);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at posedge+1 with the DUT idle; returns at posedge+1 after RESP.
   task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int g, input int r);
      bit eff_ld, mis, done;
      int n, off, exp_stall, stalls;
      bus_exp_t b;
      rsp_exp_t rr;
      eff_ld = ld;
      gnt_delay = g; rv_delay = r;
      n   = msize(eff_ld, f3);
      off = moff(n, addr);
      mis = mmisal(eff_ld, f3, addr);
      b.we = !eff_ld; b.addr = {addr[31:2], 2'b00}; b.be = '0; b.wdata = '0;
      if (!eff_ld) begin
         for (int l = 0; l < 4; l++) b.wdata[8*l +: 8] = data[8*(l % n) +: 8];
         for (int k = 0; k < n; k++) b.be[off + k] = 1'b1;
      end
      if (mis) exp_stall = 1;
      else if (g >= TIMEOUT) exp_stall = 1 + TIMEOUT;
      else if (!eff_ld) exp_stall = 2 + g;
      else if (r >= TIMEOUT) exp_stall = 2 + g + TIMEOUT;
      else exp_stall = 3 + g + r;

      if (mis) begin
         rr.flags = 3'b100; rr.chk_data = 1'b0; rr.data = '0; rsp_q.push_back(rr);
      end else if (g >= TIMEOUT) begin
         rr.flags = 3'b010; rr.chk_data = eff_ld; rr.data = '0; rsp_q.push_back(rr);
      end else begin
         bus_q.push_back(b);
         if (eff_ld) begin
            rr.chk_data = 1'b1;
            if (r >= TIMEOUT) begin rr.flags = 3'b010; rr.data = '0; end
            else begin rr.flags = 3'b001; rr.data = mload(f3, addr, ref_mem[addr[5:2]]); end
            rsp_q.push_back(rr);
         end else begin
            for (int k = 0; k < n; k++) ref_mem[addr[5:2]][8*(off + k) +: 8] = data[8*k +: 8];
         end
      end

      load_m = ld; store_m = st; funct3_m = f3; alu_out_m = addr; op_b_m = data;
      stalls = 0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (stall_o) stalls++;
         else done = 1'b1;
      end
      chk("retired", 32'(done), 32'd1);
      chk("stall_cycles", 32'(stalls), 32'(exp_stall));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      load_m = 1'b0; store_m = 1'b0;
      repeat (n) begin
         @(negedge clk);
         chk("idle_stall", 32'(stall_o), 32'd0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen, lv;
      logic [2:0] f3;
      logic [31:0] a;
      int sel, g;

      rst = 1'b1; load_m = 1'b0; store_m = 1'b0; funct3_m = '0; alu_out_m = '0; op_b_m = '0;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom; bus_mem[i] = ref_mem[i];
      end
      @(negedge clk);
      chk("rst_stall", 32'(stall_o), 0);
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_we", 32'(mem_we_o), 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_be", 32'(mem_be_o), 0);
      chk("rst_wdata", mem_wdata_o, 0);
      chk("rst_ldata", load_data_w, 0);
      chk("rst_flags", 32'({misaligned_o, bus_err_o, load_valid_w}), 0);
      @(posedge clk); #1; rst = 1'b0;
      idle(2);

      // Directed cases
      do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
      do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0);
      ref_mem[0] = 32'h0080_0000; bus_mem[0] = 32'h0080_0000;
      do_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 0);
      do_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 0);
      do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'h12345678, 20, 0);
      do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 0);
      do_access(1'b1, 1'b0, 3'b001, 32'h10B, 32'h0, 1, 2);
      do_access(1'b1, 1'b1, 3'b101, 32'h10E, 32'h0, 0, 1);
      do_access(1'b1, 1'b0, 3'b010, 32'h110, 32'h0, 0, 20);
      idle(25);

      // Reset during WAIT; the late rvalid must be ignored
      begin
         bus_exp_t b;
         b.we = 1'b0; b.addr = 32'h108; b.be = '0; b.wdata = '0;
         bus_q.push_back(b);
         gnt_delay = 0; rv_delay = 2;
         load_m = 1'b1; store_m = 1'b0; funct3_m = 3'b010; alu_out_m = 32'h108;
         seen = 1'b0;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_req_o && mem_gnt_i) seen = 1'b1;
         end
         chk("rst_grant_seen", 32'(seen), 1);
         @(posedge clk); #1;
         rst = 1'b1; load_m = 1'b0;
         @(negedge clk);
         chk("wrst_stall", 32'(stall_o), 0);
         chk("wrst_req", 32'(mem_req_o), 0);
         chk("wrst_ldata", load_data_w, 0);
         chk("wrst_flags", 32'({misaligned_o, bus_err_o, load_valid_w}), 0);
         @(posedge clk); #1; rst = 1'b0;
         lv = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (load_valid_w) lv = 1'b1;
         end
         chk("wrst_no_lvalid", 32'(lv), 0);
         chk("wrst_idle_stall", 32'(stall_o), 0);
         @(posedge clk); #1;
      end

      // Randomized accesses, some back-to-back
      for (int i = 0; i < 200; i++) begin
         a   = 32'h100 + $urandom_range(0, 63);
         f3  = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         g   = ($urandom_range(0, 19) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3);
         if (sel < 4)
            do_access(1'b1, 1'b0, f3, a, 32'h0, g, $urandom_range(0, 3));
         else if (sel < 9)
            do_access(1'b0, 1'b1, f3, a, $urandom, g, 0);
         else
            do_access(1'b1, 1'b1, f3, a, $urandom, g, $urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(4);

      chk("bus_q_empty", 32'(bus_q.size()), 0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

- Memory-stage data-access unit between the execute/memory pipeline register and the data-memory bus.
- Turns a pipelined load/store into a valid/grant/rvalid bus transaction; byte enables and lane-aligned write data for stores, sign- or zero-extension for loads.
- Holds the pipeline with `stall_o` until the access retires.
- Load results go to the write-back mux; the same signal drives the fetch/decode stalls and the stage-register enables.

## Interface
- `TIMEOUT`, default 16: cycles waited for grant or rvalid before aborting with `bus_err_o`.
- `clk`  in  1  clock; one clock domain, all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_m`  in  1  memory-stage instruction is a load.
- `store_m`  in  1  memory-stage instruction is a store.
- `funct3_m`  in  3  access size/sign code.
- `alu_out_m`  in  32  effective byte address.
- `op_b_m`  in  32  store data (rs2).
- `stall_o`  out  1  hold all upstream stages.
- `mem_req_o`  out  1  bus request.
- `mem_we_o`  out  1  1 = write.
- `mem_addr_o`  out  32  word address, bits [1:0] = 0.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  32  lane-aligned write data.
- `mem_gnt_i`  in  1  request accepted.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read data.
- `load_data_w`  out  32  extended load result.
- `load_valid_w`  out  1  one-cycle pulse, load retired.
- `misaligned_o`  out  1  one-cycle pulse, misaligned access rejected.
- `bus_err_o`  out  1  one-cycle pulse, timeout abort.

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **IDLE:**
  - On `load_m|store_m`, latch address, funct3, write data and byte enables, then go to REQ.
  - Both `load_m` and `store_m` high: treat as a load.
- **REQ:**
  - `mem_req_o`=1 and the bus outputs stay stable until `mem_gnt_i`.
  - Grant on a store: go to RESP.
  - Grant on a load: go to WAIT.
- **WAIT:** on `mem_rvalid_i`, register the extended data and go to RESP.
  - `mem_rvalid_i` is never in the grant cycle; it is ignored in IDLE/REQ/RESP.
- **RESP:**
  - `stall_o`=0; the pulse outputs are asserted here.
  - Always returns to IDLE next cycle, which then sees the next instruction.
- **`stall_o`:** = (IDLE & (`load_m`|`store_m`)) | REQ | WAIT; the IDLE term is combinational.
- **Timeout:** a counter clears on entering REQ/WAIT and increments each cycle there.
  - At `TIMEOUT`, drop `mem_req_o` and go to RESP with `bus_err_o`=1.
  - On a load timeout, `load_data_w`=0 and `load_valid_w`=0.
- **Store encoding:**
  - SB(000): be = 0001<<a[1:0], byte replicated on all lanes.
  - SH(001): be = 0011<<{a[1],0}, half replicated.
  - SW(010): be = 1111.
  - Other codes act as SW.
- **Load encoding:** select by a[1:0].
  - LB(000)/LBU(100): byte, sign-/zero-extended.
  - LH(001)/LHU(101): half by a[1], sign-/zero-extended.
  - LW(010): word.
  - Other codes act as LW.

## Timing
- **Reset:** asynchronous; state=IDLE, counter=0, every output 0. A reset mid-transaction abandons it, and a later `mem_rvalid_i` is ignored.
- **Store latency:** zero-wait grant gives stall 2 cycles (IDLE, REQ), then RESP.
- **Load latency:** zero-wait grant plus rvalid the next cycle gives stall 3 cycles (IDLE, REQ, WAIT), then RESP.
- **Back-to-back accesses:** a non-memory instruction costs no cycles; two consecutive accesses are separated by the one-cycle RESP.

## Configuration
- Macro `LSU_MISALIGN_CHECK_EN`.
- **Defined:**
  - LH/LHU/SH with a[0]=1, and LW/SW with a[1:0]≠0, issue no bus request.
  - FSM goes IDLE→RESP with `misaligned_o`=1 and `load_valid_w`=0.
  - Stall is 1 cycle.
- **Undefined:**
  - `misaligned_o` is tied 0.
  - Low address bits beyond the access size are ignored: half uses a[1], word uses a[1:0]=0.

## Structure
- **Package `lsu_pkg`:**
  - FSM state enum.
  - funct3 localparams: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Shared helper for the misalignment predicate.
- **Sub-module `load_align`:** combinational; rdata, a[1:0] and funct3 in, extended 32-bit result out. Instantiated once.

## Test plan
- SW 0xDEADBEEF @0x100, immediate grant → `mem_be_o`=1111, `mem_addr_o`=0x100, stall exactly 2 cycles.
- SB 0x000000A5 @0x103 → be=1000, wdata=0xA5A5A5A5.
- LB @0x102, rdata=0x00800000, rvalid 1 cycle after grant → `load_data_w`=0xFFFFFF80; LBU at the same address → 0x00000080; `load_valid_w` pulses 1 cycle.
- Grant withheld 20 cycles with `TIMEOUT`=16 → `bus_err_o` pulse in cycle 17 after REQ entry, `mem_req_o` low, stall released.
- LW @0x102 with macro defined → no `mem_req_o`, `misaligned_o` pulse, 1-cycle stall; with macro undefined → word read @0x100.
- `rst` asserted in WAIT, rvalid arriving 2 cycles later → outputs 0, state IDLE, no `load_valid_w`.
